// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register writers behind D and
// produces the D-stage stall request and per-operand forward selects.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int TW    = 4,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_rs,
  input  logic [AW-1:0]    d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic [AW-1:0]    d_dst,
  input  logic             d_regwrite,
  input  logic [TW-1:0]    d_tnew,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_rs_sel,
  output logic [SW-1:0]    fwd_rt_sel,
  output logic [DEPTH-1:0] occ,
  output logic [15:0]      stall_cnt
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    dst_q  [DEPTH];
  logic [AW-1:0]    dst_d  [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];
  logic [TW-1:0]    tnew_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  logic          rs_hit, rt_hit;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic [SW-1:0] rs_idx, rt_idx;
  logic          rs_stall, rt_stall;
  logic          d_issue, d_writes;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    rs_idx  = '0;
    rt_idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && (dst_q[k] == d_rs) && (d_rs != '0)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[k];
        rs_idx  = SW'(k + 1);
      end
      if (valid_q[k] && (dst_q[k] == d_rt) && (d_rt != '0)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[k];
        rt_idx  = SW'(k + 1);
      end
    end
  end

  assign rs_stall   = rs_hit && (d_tuse_rs != '1) && (rs_tnew > d_tuse_rs);
  assign rt_stall   = rt_hit && (d_tuse_rt != '1) && (rt_tnew > d_tuse_rt);
  assign stall      = d_valid && !flush && (rs_stall || rt_stall);
  assign fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_idx : '0;
  assign fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_idx : '0;

  assign d_issue  = d_valid && !stall && !flush;
  assign d_writes = d_regwrite && (d_dst != '0) && (d_tnew != '0);

  always_comb begin
    valid_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dst_d[k]  = '0;
      tnew_d[k] = '0;
    end
    if (d_issue && d_writes) begin
      valid_d[0] = 1'b1;
      dst_d[0]   = d_dst;
      tnew_d[0]  = d_tnew - TW'(1);
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      dst_d[k]   = dst_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k]  <= dst_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

  assign occ       = valid_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int TW    = 4;
  localparam int SW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             d_valid;
  logic [AW-1:0]    d_rs, d_rt, d_dst;
  logic [TW-1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic             d_regwrite, flush;
  logic             stall;
  logic [SW-1:0]    fwd_rs_sel, fwd_rt_sel;
  logic [DEPTH-1:0] occ;
  logic [15:0]      stall_cnt;

  hazard_scoreboard #(.DEPTH(DEPTH), .AW(AW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_regwrite(d_regwrite), .d_tnew(d_tnew), .flush(flush),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // -1 in any field means "not checked this cycle".
  typedef struct {
    string name;
    int    stall;
    int    rs;
    int    rt;
    int    occ;
    int    cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string fld, input int expv, input logic [31:0] act);
    if (expv < 0) return;
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "stall",      e.stall, 32'(stall));
      chk(e.name, "fwd_rs_sel", e.rs,    32'(fwd_rs_sel));
      chk(e.name, "fwd_rt_sel", e.rt,    32'(fwd_rt_sel));
      chk(e.name, "occ",        e.occ,   32'(occ));
      chk(e.name, "stall_cnt",  e.cnt,   32'(stall_cnt));
    end
  end

  task automatic drv(input bit v, input int rs, input int trs, input int rt, input int trt,
                     input int dst, input bit w, input int tn, input bit fl);
    d_valid    = v;
    d_rs       = AW'(rs);
    d_tuse_rs  = TW'(trs);
    d_rt       = AW'(rt);
    d_tuse_rt  = TW'(trt);
    d_dst      = AW'(dst);
    d_regwrite = w;
    d_tnew     = TW'(tn);
    flush      = fl;
  endtask

  task automatic cyc(input string nm, input int st, input int rs, input int rt,
                     input int oc, input int cn);
    exp_t e;
    e.name = nm; e.stall = st; e.rs = rs; e.rt = rt; e.occ = oc; e.cnt = cn;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int stalls;
    int cnt_exp;
    bit st;
    rst_n = 1'b0;
    drv(1, 0, 15, 0, 15, 3, 1, 2, 0);
    @(posedge clk);
    #1;
    cyc("rst0", -1, -1, -1, -1, -1);
    cyc("rst1", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drv(0, 0, 15, 0, 15, 0, 0, 0, 0);
    cyc("out_of_rst", 0, 0, 0, 0, 0);

    // ALU producer r8, tnew=2
    drv(1, 0, 15, 0, 15, 8, 1, 2, 0);  cyc("alu_iss",    0, 0, 0, 'h01 >> 1, 0);
    drv(1, 8, 1, 0, 15, 0, 0, 0, 0);   cyc("alu_use",    0, 0, 0, 'h01, 0);
                                       cyc("alu_fwd",    0, 2, 0, 'h02, 0);
    // Load producer r9, tnew=3
    drv(1, 0, 15, 0, 15, 9, 1, 3, 0);  cyc("ld_iss",     0, 0, 0, 'h04, 0);
    drv(1, 0, 15, 9, 1, 0, 0, 0, 0);   cyc("ld_stall",   1, 0, 0, 'h09, 0);
                                       cyc("ld_release", 0, 0, 0, 'h12, 1);
                                       cyc("ld_fwd",     0, 0, 3, 'h24, 1);
    // Back-to-back writes to r5
    drv(1, 0, 15, 0, 15, 5, 1, 2, 0);  cyc("r5_a",       0, 0, 0, 'h48, 1);
                                       cyc("r5_b",       0, 0, 0, 'h91, 1);
    drv(1, 5, 1, 5, 15, 0, 0, 0, 0);   cyc("r5_youngest",0, 0, 0, 'h23, 1);
    drv(1, 5, 1, 0, 15, 0, 0, 0, 0);   cyc("r5_fwd",     0, 2, 0, 'h46, 1);
    // Register 0 never tracked
    drv(1, 0, 0, 0, 0, 0, 1, 3, 0);    cyc("r0_wr",      0, 0, 0, 'h8C, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);    cyc("r0_rd",      0, 0, 0, 'h18, 1);
    // Flush overrides a pending stall
    drv(1, 0, 15, 0, 15, 4, 1, 3, 0);  cyc("ld_r4",      0, 0, 0, 'h30, 1);
    drv(1, 4, 0, 0, 15, 4, 1, 3, 1);   cyc("flush",      0, 0, 0, 'h61, 1);
    drv(0, 0, 15, 0, 15, 0, 0, 0, 0);  cyc("flush_bub",  0, 0, 0, 'hC2, 1);
    // Tuse boundaries against a long-latency producer
    drv(1, 0, 15, 0, 15, 7, 1, 15, 0); cyc("r7_iss",     0, 0, 0, 'h84, 1);
    drv(1, 7, 15, 7, 14, 0, 0, 0, 0);  cyc("tuse_edge",  0, 0, 0, 'h09, 1);
    drv(1, 0, 15, 7, 12, 0, 0, 0, 0);  cyc("r7_stall",   1, 0, 0, 'h12, 1);
    drv(0, 0, 15, 0, 15, 0, 0, 0, 0);  cyc("idle",       0, 0, 0, 'h24, 2);
    // Reset while stalling
    rst_n = 1'b0;
    drv(1, 0, 15, 7, 0, 0, 0, 0, 0);   cyc("rst_mid",    1, 0, 0, 'h48, 2);
    rst_n = 1'b1;                      cyc("rst_after",  0, 0, 0, 0, 0);

    // Self-dependent producer: one issue followed by DEPTH stall cycles, repeating.
    drv(1, 1, 0, 0, 15, 1, 1, 14, 0);
    stalls = 0;
    for (int i = 0; i < 9 * 8193; i++) begin
      st = (i % 9) != 0;
      cnt_exp = (stalls > 65535) ? 65535 : stalls;
      cyc("sat", int'(st), 0, 0, -1, cnt_exp);
      if (st) stalls++;
    end
    rst_n = 1'b0;
    cyc("sat_hold", -1, -1, -1, -1, 65535);
    rst_n = 1'b1;
    drv(0, 0, 15, 0, 15, 0, 0, 0, 0);
    cyc("sat_rst", 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
